// File: rtl/urv_timer_irq_src_pkg.sv
// Shared constants for the uRV timer / external-IRQ source.
// Contents: register word offsets (bus_addr_i[4:2]), CTRL bit positions,
// bus widths and a decode helper for the registers that arm the comparator.
package urv_timer_irq_src_pkg;

    localparam int unsigned TIMER_BUS_AW = 5;
    localparam int unsigned TIMER_BUS_DW = 32;

    typedef enum logic [2:0] {
        TIMER_REG_CTRL        = 3'd0,
        TIMER_REG_PRESCALE    = 3'd1,
        TIMER_REG_MTIME_LO    = 3'd2,
        TIMER_REG_MTIME_HI    = 3'd3,
        TIMER_REG_MTIMECMP_LO = 3'd4,
        TIMER_REG_MTIMECMP_HI = 3'd5,
        TIMER_REG_IRQ_PEND    = 3'd6,
        TIMER_REG_IRQ_EN      = 3'd7
    } timer_reg_t;

    localparam int unsigned CTRL_TIMER_EN  = 0;
    localparam int unsigned CTRL_TICK_PEND = 1;

    // Writes to these registers (re)arm the compare logic.
    function automatic logic is_arm_reg(timer_reg_t r);
        return (r == TIMER_REG_MTIMECMP_HI) || (r == TIMER_REG_MTIME_LO) ||
               (r == TIMER_REG_MTIME_HI);
    endfunction

endpackage

// File: rtl/urv_timer_irq_src_if.sv
// Peripheral bus between the uRV core (master) and the timer/IRQ source (slave).
// Signals: bus_addr_i (byte address), bus_data_i (write data), bus_we_i / bus_re_i
// (single-cycle strobes), bus_data_o (read data, valid with ack), bus_ack_o.
interface urv_timer_irq_src_if;
    import urv_timer_irq_src_pkg::*;

    logic [TIMER_BUS_AW-1:0] bus_addr_i;
    logic [TIMER_BUS_DW-1:0] bus_data_i;
    logic                    bus_we_i;
    logic                    bus_re_i;
    logic [TIMER_BUS_DW-1:0] bus_data_o;
    logic                    bus_ack_o;

    modport master (
        output bus_addr_i, bus_data_i, bus_we_i, bus_re_i,
        input  bus_data_o, bus_ack_o
    );

    modport slave (
        input  bus_addr_i, bus_data_i, bus_we_i, bus_re_i,
        output bus_data_o, bus_ack_o
    );

endinterface

// File: rtl/urv_irq_edge_sync.sv
// One external interrupt line: 2-flop synchronizer followed by a rising-edge
// detector flop.
// Ports: clk_i, rst_n_i (async active-low), line_i (asynchronous input),
// edge_o (one-cycle pulse on a synchronized rising edge).
module urv_irq_edge_sync (
    input  logic clk_i,
    input  logic rst_n_i,
    input  logic line_i,
    output logic edge_o
);

    logic [2:0] sync_q;

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) sync_q <= '0;
        else          sync_q <= {sync_q[1:0], line_i};
    end

    assign edge_o = sync_q[1] & ~sync_q[2];

endmodule

// File: rtl/urv_timer_irq_src.sv
// Memory-mapped interrupt source for the uRV core: prescaled 64-bit mtime with
// mtimecmp producing a one-cycle tick, plus an N-line edge-captured IRQ
// aggregator reduced to a single level interrupt.
// Ports: clk_i, rst_n_i (async active-low), bus (slave side of the peripheral
// bus), irq_lines_i (async external lines), tick_o (to exp_tick_i),
// irq_o (to exp_irq_i).
module urv_timer_irq_src
    import urv_timer_irq_src_pkg::*;
#(
    parameter int unsigned g_num_irqs       = 8,
    parameter logic [15:0] g_prescale_reset = '0
) (
    input  logic                  clk_i,
    input  logic                  rst_n_i,
    urv_timer_irq_src_if.slave    bus,
    input  logic [g_num_irqs-1:0] irq_lines_i,
    output logic                  tick_o,
    output logic                  irq_o
);

    timer_reg_t            sel;
    logic                  wr, rd;
    logic                  timer_en, tick_pend, armed;
    logic [15:0]           prescale, pc;
    logic                  pc_wrap, fire, arm_wr, tick_clr;
    logic [63:0]           mtime, mtimecmp, mtime_next;
    logic [31:0]           mtime_shadow, rdata;
    logic [g_num_irqs-1:0] pending, enable, edges, clr_mask;

    assign sel      = timer_reg_t'(bus.bus_addr_i[4:2]);
    assign wr       = bus.bus_we_i;
    assign rd       = bus.bus_re_i;
    assign pc_wrap  = timer_en && (pc == prescale);
    assign fire     = armed && (mtime >= mtimecmp);
    assign arm_wr   = wr && is_arm_reg(sel);
    assign tick_clr = wr && (sel == TIMER_REG_CTRL) && bus.bus_data_i[CTRL_TICK_PEND];
    assign clr_mask = (wr && (sel == TIMER_REG_IRQ_PEND)) ? bus.bus_data_i[g_num_irqs-1:0] : '0;

    for (genvar i = 0; i < g_num_irqs; i++) begin : g_irq
        urv_irq_edge_sync u_sync (
            .clk_i   (clk_i),
            .rst_n_i (rst_n_i),
            .line_i  (irq_lines_i[i]),
            .edge_o  (edges[i])
        );
    end

    // A software write to either half replaces the whole increment for that cycle.
    always_comb begin
        mtime_next = pc_wrap ? mtime + 64'd1 : mtime;
        if (wr && (sel == TIMER_REG_MTIME_LO))
            mtime_next = {mtime[63:32], bus.bus_data_i};
        else if (wr && (sel == TIMER_REG_MTIME_HI))
            mtime_next = {bus.bus_data_i, mtime[31:0]};
    end

    always_comb begin
        rdata = '0;
        case (sel)
            TIMER_REG_CTRL:        rdata = {30'd0, tick_pend, timer_en};
            TIMER_REG_PRESCALE:    rdata = {16'd0, prescale};
            TIMER_REG_MTIME_LO:    rdata = mtime[31:0];
            TIMER_REG_MTIME_HI:    rdata = mtime_shadow;
            TIMER_REG_MTIMECMP_LO: rdata = mtimecmp[31:0];
            TIMER_REG_MTIMECMP_HI: rdata = mtimecmp[63:32];
            TIMER_REG_IRQ_PEND:    rdata = 32'(pending);
            TIMER_REG_IRQ_EN:      rdata = 32'(enable);
            default:               rdata = '0;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            bus.bus_ack_o  <= 1'b0;
            bus.bus_data_o <= '0;
            timer_en       <= 1'b0;
            tick_pend      <= 1'b0;
            armed          <= 1'b0;
            prescale       <= g_prescale_reset;
            pc             <= '0;
            mtime          <= '0;
            mtimecmp       <= '1;
            mtime_shadow   <= '0;
            pending        <= '0;
            enable         <= '0;
            tick_o         <= 1'b0;
            irq_o          <= 1'b0;
        end else begin
            bus.bus_ack_o  <= wr | rd;
            bus.bus_data_o <= rd ? rdata : '0;
            mtime          <= mtime_next;

            if (wr && (sel == TIMER_REG_PRESCALE)) begin
                prescale <= bus.bus_data_i[15:0];
                pc       <= '0;
            end else if (timer_en) begin
                pc <= pc_wrap ? '0 : pc + 16'd1;
            end

            // Reading LO snapshots HI so a LO-then-HI pair is coherent.
            if (rd && (sel == TIMER_REG_MTIME_LO))
                mtime_shadow <= mtime[63:32];

            if (wr && (sel == TIMER_REG_CTRL))
                timer_en <= bus.bus_data_i[CTRL_TIMER_EN];
            if (wr && (sel == TIMER_REG_MTIMECMP_LO))
                mtimecmp[31:0] <= bus.bus_data_i;
            if (wr && (sel == TIMER_REG_MTIMECMP_HI))
                mtimecmp[63:32] <= bus.bus_data_i;
            if (wr && (sel == TIMER_REG_IRQ_EN))
                enable <= bus.bus_data_i[g_num_irqs-1:0];

            // Set terms take priority over the matching clear terms.
            tick_o    <= fire;
            armed     <= arm_wr | (armed & ~fire);
            tick_pend <= fire | (tick_pend & ~tick_clr);
            pending   <= (pending & ~clr_mask) | edges;
            irq_o     <= |(pending & enable);
        end
    end

endmodule
